// File: rtl/axi4_stream_if.sv
// AXI4-Stream video bus carrying one RGB pixel per beat, with frame-start (tuser)
// and end-of-line (tlast) sideband.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 30
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/awb_corr_apply.sv
// Applies gray-world white-balance gains to R and B of an RGB stream: 3-stage pipeline
// (capture, multiply, round/saturate) with frame-latched gains and one global stall.
module awb_corr_apply #(
    parameter int unsigned PX_WIDTH    = 10,
    parameter int unsigned FRACT_WIDTH = 10,
    parameter int unsigned COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi4_stream_if.slave          video_i,
    axi4_stream_if.master         video_o,
    input  logic [COEF_WIDTH-1:0] r_corr_i,
    input  logic [COEF_WIDTH-1:0] b_corr_i,
    input  logic                  bypass_i
);
    localparam int unsigned PROD_W = PX_WIDTH + COEF_WIDTH;
    localparam int unsigned SUM_W  = PROD_W + 1;

    localparam logic [COEF_WIDTH-1:0] FIXED_ONE = COEF_WIDTH'(1) << FRACT_WIDTH;
    localparam logic [SUM_W-1:0]      HALF      = SUM_W'(1) << (FRACT_WIDTH - 1);
    localparam logic [SUM_W-1:0]      PX_MAX    = {{(SUM_W - PX_WIDTH){1'b0}}, {PX_WIDTH{1'b1}}};

    logic en;
    logic new_frame;

    logic [COEF_WIDTH-1:0] r_act;
    logic [COEF_WIDTH-1:0] b_act;
    logic                  bypass_act;

    // A frame-start pixel uses the incoming gains directly, not the ones latched before it.
    logic [COEF_WIDTH-1:0] r_sel;
    logic [COEF_WIDTH-1:0] b_sel;
    logic                  bypass_sel;

    logic                  s1_valid, s1_user, s1_last, s1_byp;
    logic [PX_WIDTH-1:0]   s1_r, s1_g, s1_b;
    logic [COEF_WIDTH-1:0] s1_rc, s1_bc;

    logic                  s2_valid, s2_user, s2_last, s2_byp;
    logic [PX_WIDTH-1:0]   s2_r, s2_g, s2_b;
    logic [PROD_W-1:0]     s2_r_prod, s2_b_prod;

    logic                  s3_valid, s3_user, s3_last;
    logic [3*PX_WIDTH-1:0] s3_data;

    logic [PX_WIDTH-1:0]   r_out, b_out;

    function automatic logic [PX_WIDTH-1:0] round_sat(input logic [PROD_W-1:0] prod);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] shifted;
        sum     = {1'b0, prod} + HALF;
        shifted = sum >> FRACT_WIDTH;
        if (shifted > PX_MAX) begin
            return {PX_WIDTH{1'b1}};
        end
        return shifted[PX_WIDTH-1:0];
    endfunction

    assign en             = !s3_valid || video_o.tready;
    assign video_i.tready = en;
    assign new_frame      = video_i.tvalid && en && video_i.tuser;

    assign video_o.tvalid = s3_valid;
    assign video_o.tuser  = s3_user;
    assign video_o.tlast  = s3_last;
    assign video_o.tdata  = s3_data;

    always_comb begin
        r_sel      = r_act;
        b_sel      = b_act;
        bypass_sel = bypass_act;
        if (new_frame) begin
            r_sel      = r_corr_i;
            b_sel      = b_corr_i;
            bypass_sel = bypass_i;
        end
    end

    always_comb begin
        r_out = s2_r;
        b_out = s2_b;
        if (!s2_byp) begin
            r_out = round_sat(s2_r_prod);
            b_out = round_sat(s2_b_prod);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_act      <= FIXED_ONE;
            b_act      <= FIXED_ONE;
            bypass_act <= 1'b0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            s3_user    <= 1'b0;
            s3_last    <= 1'b0;
            s3_data    <= '0;
        end else begin
            if (new_frame) begin
                r_act      <= r_corr_i;
                b_act      <= b_corr_i;
                bypass_act <= bypass_i;
            end
            if (en) begin
                s1_valid  <= video_i.tvalid;
                s1_user   <= video_i.tuser;
                s1_last   <= video_i.tlast;
                s1_r      <= video_i.tdata[3*PX_WIDTH-1 -: PX_WIDTH];
                s1_b      <= video_i.tdata[2*PX_WIDTH-1 -: PX_WIDTH];
                s1_g      <= video_i.tdata[PX_WIDTH-1:0];
                s1_rc     <= r_sel;
                s1_bc     <= b_sel;
                s1_byp    <= bypass_sel;

                s2_valid  <= s1_valid;
                s2_user   <= s1_user;
                s2_last   <= s1_last;
                s2_byp    <= s1_byp;
                s2_r      <= s1_r;
                s2_g      <= s1_g;
                s2_b      <= s1_b;
                s2_r_prod <= PROD_W'(s1_r) * PROD_W'(s1_rc);
                s2_b_prod <= PROD_W'(s1_b) * PROD_W'(s1_bc);

                s3_valid  <= s2_valid;
                s3_user   <= s2_user;
                s3_last   <= s2_last;
                s3_data   <= {r_out, b_out, s2_g};
            end
        end
    end
endmodule

// File: tb/tb_awb_corr_apply.sv
// Directed bench for awb_corr_apply: gain, rounding/saturation, frame latching, bypass,
// reset flush and a randomly back-pressured stream against a behavioural model.
module tb_awb_corr_apply;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] r_corr = 20'd1024;
    logic [19:0] b_corr = 20'd1024;
    logic        bypass = 1'b0;
    logic        bp_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    axi4_stream_if #(.DATA_WIDTH(30)) vin ();
    axi4_stream_if #(.DATA_WIDTH(30)) vout ();

    awb_corr_apply #(
        .PX_WIDTH    (10),
        .FRACT_WIDTH (10),
        .COEF_WIDTH  (20)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .video_i  (vin),
        .video_o  (vout),
        .r_corr_i (r_corr),
        .b_corr_i (b_corr),
        .bypass_i (bypass)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        vout.tready = bp_en ? ($urandom_range(0, 99) < 55) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic u, input logic l, input logic [9:0] r,
                                       input logic [9:0] g, input logic [9:0] b);
        return {u, l, r, b, g};
    endfunction

    // Output monitor: records every output handshake and checks hold-stability across stalls.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_word;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(vout.tvalid), 64'd1);
                check("stall_hold", 64'({vout.tuser, vout.tlast, vout.tdata}), 64'(prev_word));
            end
            if (vout.tvalid && vout.tready) got_q.push_back({vout.tuser, vout.tlast, vout.tdata});
            stall_prev = vout.tvalid && !vout.tready;
            prev_word  = {vout.tuser, vout.tlast, vout.tdata};
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input logic u, input logic l, input logic [9:0] r, input logic [9:0] g,
                        input logic [9:0] b);
        logic hs;
        int   guard;
        vin.tvalid = 1'b1;
        vin.tuser  = u;
        vin.tlast  = l;
        vin.tdata  = {r, b, g};
        guard      = 0;
        do begin
            @(negedge clk);
            hs = vin.tready;
            @(posedge clk);
            #1;
            guard++;
        end while (!hs && guard < 1000);
        if (!hs) check("send_timeout", 64'd0, 64'd1);
        vin.tvalid = 1'b0;
        vin.tuser  = 1'b0;
        vin.tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_px%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    function automatic logic [9:0] gain(input logic [9:0] px, input logic [19:0] c);
        longint p;
        p = (longint'(px) * longint'(c) + 512) / 1024;
        if (p > 1023) p = 1023;
        return p[9:0];
    endfunction

    initial begin
        logic [19:0] m_r, m_b;
        logic        m_byp;
        logic [9:0]  pr, pg, pb;
        logic        pu, pl;

        vin.tvalid  = 1'b0;
        vin.tuser   = 1'b0;
        vin.tlast   = 1'b0;
        vin.tdata   = '0;
        vout.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(vout.tvalid), 64'd0);
        check("rst_tdata", 64'(vout.tdata), 64'd0);
        check("rst_tuser_tlast", 64'({vout.tuser, vout.tlast}), 64'd0);
        check("rst_tready", 64'(vin.tready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Gain and 3-cycle latency
        r_corr = 20'd1536;
        b_corr = 20'd512;
        send(1'b1, 1'b0, 10'd500, 10'd300, 10'd200);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd750, 10'd300, 10'd100));
        @(negedge clk);
        check("lat_c1", 64'(vout.tvalid), 64'd0);
        @(negedge clk);
        check("lat_c2", 64'(vout.tvalid), 64'd0);
        @(negedge clk);
        check("lat_c3", 64'(vout.tvalid), 64'd1);
        check("gain_word", 64'({vout.tuser, vout.tlast, vout.tdata}),
              64'(pk(1'b1, 1'b0, 10'd750, 10'd300, 10'd100)));
        drain("gain");

        // Saturation, rounding, zero coefficient
        r_corr = 20'd1536; b_corr = 20'd1024;
        send(1'b1, 1'b0, 10'd800, 10'd7, 10'd5);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd1023, 10'd7, 10'd5));
        r_corr = 20'd512; b_corr = 20'd0;
        send(1'b1, 1'b0, 10'd3, 10'd8, 10'd77);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd2, 10'd8, 10'd0));
        send(1'b0, 1'b1, 10'd1, 10'd9, 10'd500);
        exp_q.push_back(pk(1'b0, 1'b1, 10'd1, 10'd9, 10'd0));
        r_corr = 20'd1024; b_corr = 20'd1024;
        send(1'b1, 1'b0, 10'd1023, 10'd1, 10'd1023);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd1023, 10'd1, 10'd1023));
        drain("sat");

        // Gains latch only at frame start
        send(1'b1, 1'b0, 10'd100, 10'd10, 10'd20);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd100, 10'd10, 10'd20));
        r_corr = 20'd2048;
        send(1'b0, 1'b0, 10'd100, 10'd11, 10'd20);
        exp_q.push_back(pk(1'b0, 1'b0, 10'd100, 10'd11, 10'd20));
        send(1'b0, 1'b1, 10'd200, 10'd12, 10'd30);
        exp_q.push_back(pk(1'b0, 1'b1, 10'd200, 10'd12, 10'd30));
        send(1'b1, 1'b0, 10'd100, 10'd13, 10'd20);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd200, 10'd13, 10'd20));
        drain("latch");

        // Bypass for a whole frame, then a corrected frame
        bypass = 1'b1; r_corr = 20'd2048; b_corr = 20'd2048;
        send(1'b1, 1'b0, 10'd100, 10'd1, 10'd40);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd100, 10'd1, 10'd40));
        send(1'b0, 1'b0, 10'd50, 10'd2, 10'd41);
        exp_q.push_back(pk(1'b0, 1'b0, 10'd50, 10'd2, 10'd41));
        bypass = 1'b0;
        send(1'b0, 1'b1, 10'd60, 10'd3, 10'd42);
        exp_q.push_back(pk(1'b0, 1'b1, 10'd60, 10'd3, 10'd42));
        send(1'b1, 1'b0, 10'd100, 10'd4, 10'd40);
        exp_q.push_back(pk(1'b1, 1'b0, 10'd200, 10'd4, 10'd80));
        drain("bypass");

        // Reset with three pixels in flight; gains return to unity
        send(1'b0, 1'b0, 10'd10, 10'd1, 10'd10);
        send(1'b0, 1'b0, 10'd11, 10'd1, 10'd11);
        send(1'b0, 1'b0, 10'd12, 10'd1, 10'd12);
        rst        = 1'b1;
        r_corr     = 20'd3072;
        vin.tvalid = 1'b1;
        vin.tuser  = 1'b1;
        vin.tdata  = {10'd99, 10'd99, 10'd99};
        @(negedge clk);
        check("rst_accept_tready", 64'(vin.tready), 64'd1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        vin.tvalid = 1'b0;
        vin.tuser  = 1'b0;
        @(negedge clk);
        check("rst_flush_tvalid", 64'(vout.tvalid), 64'd0);
        got_q.delete();
        r_corr = 20'd2048;
        @(posedge clk);
        #1;
        send(1'b0, 1'b1, 10'd100, 10'd5, 10'd60);
        exp_q.push_back(pk(1'b0, 1'b1, 10'd100, 10'd5, 10'd60));
        drain("rst");

        // Random back-pressure stream against the model
        bp_en = 1'b1;
        m_r = 20'd1024; m_b = 20'd1024; m_byp = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            r_corr = 20'($urandom_range(0, 3000));
            b_corr = 20'($urandom_range(0, 3000));
            bypass = ($urandom_range(0, 3) == 0);
            pu = (i % 100 == 0);
            pl = (i % 20 == 19);
            pr = 10'($urandom_range(0, 1023));
            pg = 10'($urandom_range(0, 1023));
            pb = 10'($urandom_range(0, 1023));
            if (pu) begin
                m_r = r_corr; m_b = b_corr; m_byp = bypass;
            end
            exp_q.push_back(pk(pu, pl, m_byp ? pr : gain(pr, m_r), pg, m_byp ? pb : gain(pb, m_b)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(pu, pl, pr, pg, pb);
        end
        drain("stream");
        bp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/awb_corr_apply.md
AWB_CORR_APPLY -- requirements
Module: awb_corr_apply

Interface
REQ-001 Parameter PX_WIDTH, default 10: bits per colour component.
REQ-002 Parameter FRACT_WIDTH, default 10: fractional bits of the correction coefficients.
REQ-003 Parameter COEF_WIDTH, default PX_WIDTH + FRACT_WIDTH: coefficient width, unsigned fixed point with FRACT_WIDTH fraction bits.
REQ-004 Port clk_i  input  1: the only clock.
REQ-005 Port rst_i  input  1: reset, synchronous to clk_i and active-high.
REQ-006 Port video_i  axi4_stream_if.slave  tdata 3*PX_WIDTH plus tvalid, tready, tuser, tlast: input pixel stream.
REQ-007 Port video_o  axi4_stream_if.master  tdata 3*PX_WIDTH plus tvalid, tready, tuser, tlast: corrected pixel stream.
REQ-008 Port r_corr_i  input  COEF_WIDTH: red gain from the gray-world estimator.
REQ-009 Port b_corr_i  input  COEF_WIDTH: blue gain from the gray-world estimator.
REQ-010 Port bypass_i  input  1: pass pixels through uncorrected.

Function
REQ-011 The tdata layout SHALL be R = [3*PX_WIDTH-1 -: PX_WIDTH], B = [2*PX_WIDTH-1 -: PX_WIDTH], G = [PX_WIDTH-1:0] on both ports.
REQ-012 The pipeline SHALL have 3 register stages: S1 input capture, S2 multiply, S3 round and saturate. Latency is 3 clk_i cycles from input handshake to video_o.tvalid when not stalled.
REQ-013 The pipeline SHALL use one global stall: en = !video_o.tvalid || video_o.tready, video_i.tready = en, and all stages advance only when en = 1.
REQ-014 The throughput SHALL be 1 pixel per cycle while video_o.tready = 1.
REQ-015 While video_o.tvalid = 1 and video_o.tready = 0, video_o.tdata, tuser and tlast SHALL be held stable.
REQ-016 Each stage SHALL carry its own valid bit. Bubbles (tvalid = 0 at the input) SHALL propagate as invalid slots and SHALL NOT be emitted.
REQ-017 Active coefficients r_act, b_act and bypass_act SHALL load from r_corr_i, b_corr_i and bypass_i only on an input handshake with tuser = 1. That first pixel and the rest of its frame SHALL use the new values.
REQ-018 Changes on r_corr_i, b_corr_i or bypass_i between frame starts SHALL have no effect on the current frame.
REQ-019 Each in-flight pixel SHALL carry the coefficients and bypass value captured for it in S1.
REQ-020 The R product SHALL be R * r_act at full width PX_WIDTH + COEF_WIDTH, with no truncation before rounding. The B product SHALL be formed the same way from B and b_act.
REQ-021 Rounding SHALL add 2^(FRACT_WIDTH-1) to the product, then shift right by FRACT_WIDTH (round half up).
REQ-022 If the rounded result exceeds 2^PX_WIDTH - 1, the output SHALL saturate to 2^PX_WIDTH - 1. A coefficient of 0 SHALL yield 0.
REQ-023 G SHALL pass unmodified, delayed to stay aligned with R and B.
REQ-024 When bypass applies to a pixel, R and B SHALL pass unmodified with the same 3-cycle latency.
REQ-025 tuser and tlast SHALL travel with their pixel through all stages.
REQ-026 An input handshake and an output handshake in the same cycle SHALL both complete with no loss or duplication.
REQ-027 A tuser = 1 pixel arriving while earlier-frame pixels are still in flight SHALL NOT change the coefficients applied to those earlier pixels.

Reset
REQ-028 On rst_i = 1 at a clk_i edge, all stage valid bits, video_o.tvalid, video_o.tuser and video_o.tlast SHALL clear to 0.
REQ-029 On reset, video_o.tdata SHALL clear to 0.
REQ-030 On reset, r_act and b_act SHALL load FIXED_ONE (1 << FRACT_WIDTH) and bypass_act SHALL load 0.
REQ-031 Reset asserted mid-frame SHALL discard all in-flight pixels; none of them SHALL appear on video_o after reset releases.
REQ-032 While rst_i = 1, video_i.tready SHALL follow REQ-013, which gives 1 because video_o.tvalid = 0. Input accepted during reset SHALL be discarded.

Verification (PX_WIDTH = 10, FRACT_WIDTH = 10)
REQ-033 Gain: tuser pixel R = 500, G = 300, B = 200 with r_corr_i = 1536 and b_corr_i = 512 -> 3 cycles later R = 750, G = 300, B = 100, tuser = 1.
REQ-034 Saturation and rounding: R = 800 at r = 1536 -> 1023; R = 3 at r = 512 -> 2; R = 1023 at r = 1024 -> 1023.
REQ-035 Frame-boundary latching: r_corr_i changes from 1024 to 2048 mid-frame -> the rest of that frame is unchanged; the next tuser pixel R = 100 -> 200.
REQ-036 Backpressure: random video_o.tready with a 1000-pixel stream -> output equals the reference model in order, and tdata is stable during every stall.
REQ-037 Bypass: bypass_i = 1 at a tuser pixel with r_corr_i = 2048 -> R is unchanged for the whole frame; the next frame with bypass_i = 0 is doubled.
REQ-038 Reset: assert rst_i with 3 pixels in flight -> video_o.tvalid = 0 next cycle, and the first post-reset frame before any tuser uses gain 1024.
